// File: rtl/wsum_pkg.sv
// rtl/wsum_pkg.sv - shared constants and helpers for the weighted-sum adder tree
//
// Purpose : sizing helpers (clog2, internal width, stage count, per-level
//           element counts/offsets) and the overflow / saturate-or-wrap
//           output conversion used by wsum_tree_pipe.
// Config  : WSUM_SATURATE_EN - when defined, out-of-range sums clamp to the
//           signed SUM_W limits; otherwise they wrap (two's-complement
//           truncation). Overflow is reported in both builds.
// Ports   : none (package).
package wsum_pkg;

  // Widest intermediate handled by the output conversion helpers.
  localparam int MAX_W = 128;

`ifdef WSUM_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Full-precision internal width: a sum of n W-bit terms never needs more.
  function automatic int calc_iw(input int w, input int n);
    return w + clog2(n);
  endfunction

  // Register stages before the output register: terms + one per tree level.
  function automatic int calc_l(input int n);
    return clog2(n) + 1;
  endfunction

  // Element count at tree level k (level 0 holds the n gated terms).
  function automatic int levels_count(input int n, input int k);
    int c;
    c = n;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Element offset of level k inside the flattened tree bus.
  function automatic int level_offset(input int n, input int k);
    int off;
    off = 0;
    for (int i = 0; i < k; i++) off += levels_count(n, i);
    return off;
  endfunction

  // Largest positive value representable in sum_w signed bits; its
  // complement is the most negative value.
  function automatic logic signed [MAX_W-1:0] sat_max(input int sum_w);
    return signed'((MAX_W'(1) << (sum_w - 1)) - MAX_W'(1));
  endfunction

  function automatic logic ovf_check(input logic signed [MAX_W-1:0] value,
                                     input int iw, input int sum_w);
    logic signed [MAX_W-1:0] hi;
    hi = sat_max(sum_w);
    if (iw <= sum_w) return 1'b0;
    return (value > hi) || (value < ~hi);
  endfunction

  // Caller keeps the low SUM_W bits; without saturation that is the wrap.
  function automatic logic signed [MAX_W-1:0] sat_trunc(input logic signed [MAX_W-1:0] value,
                                                        input int iw, input int sum_w);
    logic signed [MAX_W-1:0] hi;
    hi = sat_max(sum_w);
    if (SAT_EN && ovf_check(value, iw, sum_w))
      return value[MAX_W-1] ? ~hi : hi;
    return value;
  endfunction

endpackage

// File: rtl/wsum_tree_level.sv
// rtl/wsum_tree_level.sv - one registered pairwise-reduction level of the adder tree
//
// Purpose : adds elements (2j, 2j+1) into output element j; an odd last
//           element passes through unchanged. Data and valid hold when en=0.
// Ports   : clk, rst_n (async, active-low), en (pipeline advance),
//           in_valid/in_data (IN_CNT elements of IW bits),
//           out_valid/out_data (ceil(IN_CNT/2) elements of IW bits).
module wsum_tree_level
  import wsum_pkg::*;
#(
  parameter int IN_CNT = 2,
  parameter int IW     = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic                                  in_valid,
  input  logic [IN_CNT*IW-1:0]                  in_data,
  output logic                                  out_valid,
  output logic [levels_count(IN_CNT, 1)*IW-1:0] out_data
);

  localparam int OUT_CNT = levels_count(IN_CNT, 1);

  logic [OUT_CNT*IW-1:0] nxt;

  for (genvar j = 0; j < OUT_CNT; j++) begin : g_pair
    if (2 * j + 1 < IN_CNT) begin : g_add
      assign nxt[j*IW +: IW] = in_data[(2*j)*IW +: IW] + in_data[(2*j+1)*IW +: IW];
    end else begin : g_pass
      assign nxt[j*IW +: IW] = in_data[(2*j)*IW +: IW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= nxt;
    end
  end

endmodule

// File: rtl/wsum_tree_pipe.sv
// rtl/wsum_tree_pipe.sv - pipelined weighted sum of N binary inputs and N signed weights
//
// Purpose : sum = sum_i x[i]*w[i] through a registered binary adder tree,
//           then an output register that applies wrap/saturation and flags
//           overflow. A beat accepted at edge t shows out_valid after edge
//           t+L, L = clog2(N)+1. One global enable stalls the whole pipe.
// Config  : WSUM_SATURATE_EN (see wsum_pkg) selects clamp instead of wrap.
// Ports   : clk, rst_n (async, active-low);
//           in_valid/in_ready, x[N], w[W*N] (weight i at [W*(i+1)-1:W*i]);
//           out_valid/out_ready, sum[SUM_W], overflow.
//           in_ready is combinational from out_ready (no skid buffer).
module wsum_tree_pipe
  import wsum_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 32,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [W*N-1:0]   w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic             overflow
);

  localparam int IW  = calc_iw(W, N);
  localparam int L   = calc_l(N);
  localparam int TOT = level_offset(N, L);

  logic                    en;
  logic [N*IW-1:0]         terms;
  logic [N*IW-1:0]         s0_data;
  logic                    s0_valid;
  // All tree levels flattened back to back; level k starts at level_offset(N,k).
  wire  [TOT*IW-1:0]       tree_data;
  wire  [L-1:0]            tree_valid;
  logic [IW-1:0]           final_val;
  logic signed [MAX_W-1:0] final_ext;

  // The pipe only moves when the output slot is empty or being drained.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  always_comb begin
    terms = '0;
    for (int i = 0; i < N; i++)
      if (x[i]) terms[i*IW +: IW] = IW'($signed(w[i*W +: W]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
    end else if (en) begin
      s0_valid <= in_valid;
      s0_data  <= terms;
    end
  end

  assign tree_data[N*IW-1:0] = s0_data;
  assign tree_valid[0]       = s0_valid;

  for (genvar k = 1; k < L; k++) begin : g_level
    localparam int IN_CNT  = levels_count(N, k - 1);
    localparam int OUT_CNT = levels_count(N, k);
    localparam int IN_OFF  = level_offset(N, k - 1);
    localparam int OUT_OFF = level_offset(N, k);

    wsum_tree_level #(
      .IN_CNT (IN_CNT),
      .IW     (IW)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (tree_valid[k-1]),
      .in_data   (tree_data[IN_OFF*IW +: IN_CNT*IW]),
      .out_valid (tree_valid[k]),
      .out_data  (tree_data[OUT_OFF*IW +: OUT_CNT*IW])
    );
  end

  assign final_val = tree_data[(TOT-1)*IW +: IW];
  assign final_ext = MAX_W'($signed(final_val));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      overflow  <= 1'b0;
    end else if (en) begin
      out_valid <= tree_valid[L-1];
      sum       <= SUM_W'(sat_trunc(final_ext, IW, SUM_W));
      overflow  <= ovf_check(final_ext, IW, SUM_W);
    end
  end

endmodule

// File: tb/tb_wsum_tree_pipe.sv
// tb/tb_wsum_tree_pipe.sv - directed self-checking bench for wsum_tree_pipe
module tb_wsum_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         iv8, ir8, ov8, or8, of8;
  logic [7:0]   x8;
  logic [255:0] w8;
  logic [31:0]  s8;

  logic         iv5, ir5, ov5, or5, of5;
  logic [4:0]   x5;
  logic [159:0] w5;
  logic [31:0]  s5;

  int vectors     = 0;
  int miscompares = 0;

  wsum_tree_pipe #(.N(8), .W(32), .SUM_W(32)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .x(x8), .w(w8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .overflow(of8)
  );

  wsum_tree_pipe #(.N(5), .W(32), .SUM_W(32)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5), .x(x5), .w(w5),
    .out_valid(ov5), .out_ready(or5), .sum(s5), .overflow(of5)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill8(input logic [31:0] v);
    for (int i = 0; i < 8; i++) w8[i*32 +: 32] = v;
  endtask

  task automatic send8(input logic [7:0] xv);
    x8  = xv;
    iv8 = 1'b1;
    step();
    iv8 = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!ov8 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic wait5(output int lat);
    lat = 0;
    while (!ov5 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, got, first_c, last_c, k, n;
    logic fire;
    logic [31:0] exp_q [3];

    rst_n = 1'b0;
    iv8 = 1'b0; x8 = '0; w8 = '0; or8 = 1'b1;
    iv5 = 1'b0; x5 = '0; w5 = '0; or5 = 1'b1;
    step();
    step();
    check("rst_out_valid", 64'(ov8), 0);
    check("rst_sum", 64'(s8), 0);
    check("rst_overflow", 64'(of8), 0);
    check("rst_out_valid_n5", 64'(ov5), 0);
    rst_n = 1'b1;
    step();
    check("in_ready_after_rst", 64'(ir8), 1);

    // Latency and basic sums: w[i]=i+1
    for (int i = 0; i < 8; i++) w8[i*32 +: 32] = 32'(i + 1);
    send8(8'hFF);
    wait8(lat);
    check("lat_ff", 64'(lat), 4);
    check("sum_ff", 64'(s8), 36);
    check("ovf_ff", 64'(of8), 0);
    send8(8'h0F);
    wait8(lat);
    check("lat_0f", 64'(lat), 4);
    check("sum_0f", 64'(s8), 10);

    // 16 back-to-back beats, w[i]=k -> sum 8k, one per cycle
    k = 0; got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30; c++) begin
      iv8 = (k < 16);
      x8  = 8'hFF;
      fill8(32'(k));
      fire = iv8 & ir8;
      step();
      if (fire) k++;
      if (ov8) begin
        check("b2b_sum", 64'(s8), 64'(8 * got));
        got++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    iv8 = 1'b0;
    check("b2b_count", 64'(got), 16);
    check("b2b_span", 64'(last_c - first_c), 15);

    // Stall with 3 beats in flight
    exp_q = '{32'd80, 32'd160, 32'd240};
    x8 = 8'hFF;
    for (int b = 0; b < 3; b++) begin
      fill8(32'(10 * (b + 1)));
      iv8 = 1'b1;
      step();
    end
    iv8 = 1'b0;
    or8 = 1'b0;
    wait8(lat);
    check("stall_valid", 64'(ov8), 1);
    for (int c = 0; c < 5; c++) begin
      check("stall_in_ready", 64'(ir8), 0);
      check("stall_sum_hold", 64'(s8), 80);
      step();
    end
    or8 = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (ov8) begin
        if (n < 3) check("stall_drain", 64'(s8), 64'(exp_q[n]));
        n++;
      end
      step();
    end
    check("stall_count", 64'(n), 3);

    // Overflow and range boundaries
    fill8(32'h7FFF_FFFF);
    send8(8'hFF);
    wait8(lat);
`ifdef WSUM_SATURATE_EN
    check("ovf_pos_sum", 64'(s8), 64'h7FFF_FFFF);
`else
    check("ovf_pos_sum", 64'(s8), 64'hFFFF_FFF8);
`endif
    check("ovf_pos_flag", 64'(of8), 1);

    fill8(32'h8000_0000);
    send8(8'hFF);
    wait8(lat);
`ifdef WSUM_SATURATE_EN
    check("ovf_neg_sum", 64'(s8), 64'h8000_0000);
`else
    check("ovf_neg_sum", 64'(s8), 64'h0);
`endif
    check("ovf_neg_flag", 64'(of8), 1);

    fill8(32'h0FFF_FFFF);
    send8(8'hFF);
    wait8(lat);
    check("edge_pos_sum", 64'(s8), 64'h7FFF_FFF8);
    check("edge_pos_flag", 64'(of8), 0);

    fill8(32'hF000_0000);
    send8(8'hFF);
    wait8(lat);
    check("edge_min_sum", 64'(s8), 64'h8000_0000);
    check("edge_min_flag", 64'(of8), 0);

    w8 = '0;
    w8[31:0]  = 32'h7FFF_FFFF;
    w8[63:32] = 32'h0000_0001;
    send8(8'h03);
    wait8(lat);
`ifdef WSUM_SATURATE_EN
    check("over_max_sum", 64'(s8), 64'h7FFF_FFFF);
`else
    check("over_max_sum", 64'(s8), 64'h8000_0000);
`endif
    check("over_max_flag", 64'(of8), 1);

    w8[31:0]  = 32'h8000_0000;
    w8[63:32] = 32'hFFFF_FFFF;
    send8(8'h03);
    wait8(lat);
`ifdef WSUM_SATURATE_EN
    check("under_min_sum", 64'(s8), 64'h8000_0000);
`else
    check("under_min_sum", 64'(s8), 64'h7FFF_FFFF);
`endif
    check("under_min_flag", 64'(of8), 1);

    // N=5: w = {-3, 7, 9, 100, -50} for i=4..0
    w5 = {32'hFFFF_FFFD, 32'd7, 32'd9, 32'd100, 32'hFFFF_FFCE};
    x5 = 5'b10101;
    iv5 = 1'b1;
    step();
    iv5 = 1'b0;
    wait5(lat);
    check("n5_lat", 64'(lat), 4);
    check("n5_sum", 64'(s5), 64'hFFFF_FFD4);
    check("n5_ovf", 64'(of5), 0);
    x5 = 5'b11111;
    iv5 = 1'b1;
    step();
    iv5 = 1'b0;
    wait5(lat);
    check("n5_all_lat", 64'(lat), 4);
    check("n5_all_sum", 64'(s5), 63);

    // Reset mid-stream with beats in flight
    fill8(32'd5);
    x8 = 8'hFF;
    for (int b = 0; b < 3; b++) begin
      iv8 = 1'b1;
      step();
    end
    iv8 = 1'b0;
    wait8(lat);
    check("mid_valid_before", 64'(ov8), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(ov8), 0);
    check("mid_rst_sum", 64'(s8), 0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ov8) n++;
    end
    check("mid_no_stale", 64'(n), 0);
    fill8(32'd3);
    send8(8'hFF);
    wait8(lat);
    check("mid_next_lat", 64'(lat), 4);
    check("mid_next_sum", 64'(s8), 24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wsum_tree_pipe.md
Name: wsum_tree_pipe

Overview:
- Pipelined, parametrised weighted-sum unit for the single-layer perceptron: sum = Σ x[i]·w[i] over N binary inputs and N signed weights.
- Replaces the serial N-stage chain with a registered binary adder tree of depth ceil(log2 N).
- Adds a valid/ready handshake, a global stall and overflow detection.
- Feeds the perceptron activation/threshold stage.

Parameters:
- N, 8, number of inputs/weights (N ≥ 1, need not be a power of 2).
- W, 32, weight width, two's complement.
- SUM_W, 32, output width, two's complement (SUM_W ≤ W + ceil(log2 N)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  x/w beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- x  in  N  binary inputs; x[i] gates weight i.
- w  in  W*N  weights packed; weight i at [W*(i+1)-1 : W*i].
- out_valid  out  1  sum/overflow valid.
- out_ready  in  1  downstream accepts.
- sum  out  SUM_W  weighted sum.
- overflow  out  1  full-precision sum outside the signed SUM_W range; aligned with sum.

Behaviour:
- Reset: clk single clock; rst_n asynchronous, active-low.
  - While asserted: out_valid=0, sum=0, overflow=0, all stage valid bits 0.
  - in_ready=1 once reset releases.
  - Reset mid-operation discards all in-flight beats; no partial output appears after release.
- Internal width is IW = W + ceil(log2 N), full precision. Each term is sign-extended w[i] when x[i]=1, else 0.
- Stage 0 registers the N gated, sign-extended terms.
- Stage k (1..L-1) registers the pairwise sums of stage k-1, where L = ceil(log2 N)+1.
  - At an odd count, the last element passes through registered unchanged.
  - N=1 gives L=1: terms register and go straight to the output.
- Output register: sum = low SUM_W bits of the final IW value (or saturated, see the optional feature). overflow = final value > 2^(SUM_W-1)-1 or < -2^(SUM_W-1). overflow is always computed.
- Latency:
  - A beat accepted at edge t presents out_valid=1 after edge t+L (output register included in L's final stage).
  - With out_ready held high, throughput is 1 beat/cycle.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Global enable en = ~out_valid | out_ready; in_ready = en.
  - When en=0 every stage, including the valid bits, holds.
  - sum/overflow must stay stable while out_valid=1 & out_ready=0.
- Bubbles: in_valid=0 while en=1 inserts a 0 valid bit; the data registers may update but are don't-care.
- Simultaneous input accept and output drain in the same cycle is legal and loses no data.
- in_ready combinationally depends on out_ready; this is documented and acceptable. No skid buffer.

Optional Feature:
- WSUM_SATURATE_EN defined: on overflow, sum clamps to 2^(SUM_W-1)-1 (positive) or -2^(SUM_W-1) (negative); overflow=1.
- Undefined: sum is the two's-complement wrap (truncation); overflow still reported.
- Latency is identical in both builds.

Decomposition:
- Package wsum_pkg:
  - Function clog2.
  - Localparam helpers for IW and L.
  - Function levels_count(n, k), giving the element count at tree level k.
  - Function sat_trunc(value, IW, SUM_W).
- Sub-module wsum_tree_level: one registered reduction level with parameters IN_CNT and IW, plus en.
  - It pairs and adds elements, passes an odd tail through, and registers valid.
  - Instantiated L-1 times via generate.

Test Plan:
- N=8, W=SUM_W=32, x=8'hFF, w[i]=i+1, out_ready=1 → exactly 4 cycles after acceptance: sum=36, overflow=0; x=8'h0F → sum=10.
- N=8, back-to-back 16 beats with x=8'hFF and w[i]=k (beat k) → 16 consecutive outputs sum=8k, in order, one per cycle.
- Stall: pulse out_ready=0 for 5 cycles while 3 beats are in flight → in_ready=0 during the stall; sum held stable; all 3 results delivered in order with no drops or duplicates.
- Overflow: SUM_W=32, all x=1, w[i]=32'h7FFF_FFFF → overflow=1. With WSUM_SATURATE_EN: sum=32'h7FFF_FFFF. Without: sum=32'hFFFF_FFF8 (wrap). All w[i]=32'h8000_0000 (SAT build) → sum=32'h8000_0000, overflow=1.
- N=5 (non-power-of-2), x=5'b10101, w={-3,7,9,100,-50} for i=4..0 → sum=-44 after L=4 cycles.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 beats in flight → out_valid=0 immediately; after release, no stale output appears and the next beat's latency is unchanged.
